// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory/MMIO bus arbiter.
//   - requester indices (data, fetch, DMA)
//   - FSM state encoding
//   - latched bus payload struct
//   - one-hot to index helper
package mem_arbiter_pkg;

  localparam int NUM_REQ   = 3;
  localparam int REQ_DATA  = 0;
  localparam int REQ_FETCH = 1;
  localparam int REQ_DMA   = 2;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_STALL  = 2'd2,
    ARB_DONE   = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic [15:0] addr;     // byte address
    logic        we;
    logic        is_byte;
    logic [15:0] wdata;
  } bus_req_t;

  function automatic logic [1:0] onehot_idx(input logic [NUM_REQ-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NUM_REQ; i++)
      if (oh[i]) idx = 2'(i);
    return idx;
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational requester picker.
//   req_valid  in  N  request valid per requester
//   starve_hit in  1  highest-index requester has lost enough rounds
//   winner     out N  one-hot winner (all zero when nothing is valid)
// Lowest valid index wins, except the top index jumps the queue on starve_hit.
module arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int N = NUM_REQ
) (
  input  logic [N-1:0] req_valid,
  input  logic         starve_hit,
  output logic [N-1:0] winner
);

  always_comb begin
    winner = '0;
    if (req_valid[N-1] && starve_hit) begin
      winner[N-1] = 1'b1;
    end else begin
      // scan high to low so the lowest valid index is the last write
      for (int i = N - 1; i >= 0; i--)
        if (req_valid[i]) winner = N'(1) << i;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Three-requester arbiter in front of the shared mem and mmio blocks.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/addr/we/byte/wdata  per-requester request (16-bit slices)
//   req_gnt                       one-hot, payload taken at this edge
//   req_done, req_err, rdata      one-cycle completion, timeout flag, read data
//   bus_*                         latched payload presented to both targets
//   mem_en/mem_rdata/mem_wait     mem target strobe and response
//   mmio_en/mmio_rdata/mmio_wait  mmio target strobe and response
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter logic [15:0] MMIO_BASE    = 16'hFF00,
  parameter int          STARVE_LIMIT = 4,
  parameter int          WAIT_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req_valid,
  input  logic [47:0] req_addr,
  input  logic [2:0]  req_we,
  input  logic [2:0]  req_byte,
  input  logic [47:0] req_wdata,
  output logic [2:0]  req_gnt,
  output logic [2:0]  req_done,
  output logic        req_err,
  output logic [15:0] rdata,
  output logic [15:0] bus_addr,
  output logic        bus_byte_select,
  output logic        bus_byte_enable,
  output logic        bus_we,
  output logic [15:0] bus_wdata,
  output logic        mem_en,
  input  logic [15:0] mem_rdata,
  input  logic        mem_wait,
  output logic        mmio_en,
  input  logic [15:0] mmio_rdata,
  input  logic        mmio_wait
);

  localparam int SCW = $clog2(STARVE_LIMIT + 1);
  localparam int WCW = $clog2(WAIT_TIMEOUT + 1);

  arb_state_e     state_q, state_d;
  bus_req_t       breq_q, breq_d;
  logic           tgt_q, tgt_d;         // 1: mmio, 0: mem
  logic [1:0]     owner_q, owner_d;
  logic           err_q, err_d;
  logic [15:0]    rdata_q, rdata_d;
  logic [SCW-1:0] starve_cnt_q, starve_cnt_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;

  logic [2:0]  winner, gnt;
  logic        arb_phase, starve_hit, sel_wait, busy;
  logic [1:0]  win_idx;
  logic [15:0] sel_rdata, cap_rdata, win_addr;

  assign starve_hit = (starve_cnt_q == SCW'(STARVE_LIMIT));

  arb_pick #(.N(NUM_REQ)) u_pick (
    .req_valid  (req_valid),
    .starve_hit (starve_hit),
    .winner     (winner)
  );

  always_comb begin
    arb_phase = (state_q == ARB_IDLE) || (state_q == ARB_DONE);
    // no grant while reset is held, so nothing is handed out that reset drops
    gnt       = (arb_phase && !rst) ? winner : 3'b000;
    win_idx   = onehot_idx(winner);
    win_addr  = req_addr[16*win_idx +: 16];
    sel_wait  = tgt_q ? mmio_wait  : mem_wait;
    sel_rdata = tgt_q ? mmio_rdata : mem_rdata;
    cap_rdata = breq_q.we ? 16'h0000 : sel_rdata;

    state_d      = state_q;
    breq_d       = breq_q;
    tgt_d        = tgt_q;
    owner_d      = owner_q;
    err_d        = err_q;
    rdata_d      = rdata_q;
    starve_cnt_d = starve_cnt_q;
    wait_cnt_d   = wait_cnt_q;

    case (state_q)
      ARB_IDLE, ARB_DONE: begin
        if (|gnt) begin
          state_d        = ARB_ACCESS;
          owner_d        = win_idx;
          breq_d.addr    = win_addr;
          breq_d.we      = req_we[win_idx];
          breq_d.is_byte = req_byte[win_idx];
          breq_d.wdata   = req_wdata[16*win_idx +: 16];
          tgt_d          = (win_addr >= MMIO_BASE);
          err_d          = 1'b0;
          wait_cnt_d     = '0;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_ACCESS: begin
        if (sel_wait) begin
          state_d    = ARB_STALL;
          wait_cnt_d = WCW'(1);
        end else begin
          state_d = ARB_DONE;
          rdata_d = cap_rdata;
          err_d   = 1'b0;
        end
      end
      ARB_STALL: begin
        if (!sel_wait) begin
          state_d = ARB_DONE;
          rdata_d = cap_rdata;
          err_d   = 1'b0;
        end else if (wait_cnt_q == WCW'(WAIT_TIMEOUT)) begin
          state_d = ARB_DONE;
          rdata_d = 16'h0000;
          err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    // DMA loss counter: only counts rounds DMA actually contended for
    if (!req_valid[REQ_DMA])
      starve_cnt_d = '0;
    else if (|gnt) begin
      if (gnt[REQ_DMA])    starve_cnt_d = '0;
      else if (!starve_hit) starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      breq_q       <= '0;
      tgt_q        <= 1'b0;
      owner_q      <= 2'd0;
      err_q        <= 1'b0;
      rdata_q      <= 16'h0000;
      starve_cnt_q <= '0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      breq_q       <= breq_d;
      tgt_q        <= tgt_d;
      owner_q      <= owner_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      starve_cnt_q <= starve_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign busy            = (state_q == ARB_ACCESS) || (state_q == ARB_STALL);
  assign req_gnt         = gnt;
  assign req_done        = (state_q == ARB_DONE) ? (3'b001 << owner_q) : 3'b000;
  assign req_err         = (state_q == ARB_DONE) && err_q;
  assign rdata           = rdata_q;
  assign bus_addr        = {1'b0, breq_q.addr[15:1]};
  assign bus_byte_select = breq_q.addr[0];
  assign bus_byte_enable = breq_q.is_byte;
  assign bus_we          = breq_q.we;
  assign bus_wdata       = breq_q.wdata;
  assign mem_en          = busy && !tgt_q;
  assign mmio_en         = busy && tgt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic, all checked
// against a transaction-level model (per-transaction wait length decides when
// done arrives; priority and DMA loss count are tracked as plain integers).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid, req_we, req_byte, req_gnt, req_done;
  logic [47:0] req_addr, req_wdata;
  logic        req_err, bus_byte_select, bus_byte_enable, bus_we;
  logic [15:0] rdata, bus_addr, bus_wdata, mem_rdata, mmio_rdata;
  logic        mem_en, mem_wait, mmio_en, mmio_wait;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_we(req_we),
    .req_byte(req_byte), .req_wdata(req_wdata),
    .req_gnt(req_gnt), .req_done(req_done), .req_err(req_err), .rdata(rdata),
    .bus_addr(bus_addr), .bus_byte_select(bus_byte_select),
    .bus_byte_enable(bus_byte_enable), .bus_we(bus_we), .bus_wdata(bus_wdata),
    .mem_en(mem_en), .mem_rdata(mem_rdata), .mem_wait(mem_wait),
    .mmio_en(mmio_en), .mmio_rdata(mmio_rdata), .mmio_wait(mmio_wait)
  );

  int n_cmp = 0, n_bad = 0;

  // requester side: pending request held until granted
  bit          pend[3];
  logic [15:0] p_addr[3], p_wdata[3];
  bit          p_we[3], p_byte[3];
  bit          auto_req = 0;
  int          req_rate = 40;
  int          w_next   = 0;    // wait length for next grant, -1 = random

  // in-flight transaction model
  bit          busy = 0;
  int          cyc = 0, g_cyc = 0, g_w = 0, g_idx = 0, losses = 0;
  logic [15:0] g_addr, g_wdata, exp_rdata;
  bit          g_we, g_byte, g_mmio;
  int          gcount[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic new_req(input int i, input logic [15:0] a, input bit we,
                         input bit by, input logic [15:0] wd);
    pend[i] = 1; p_addr[i] = a; p_we[i] = we; p_byte[i] = by; p_wdata[i] = wd;
  endtask

  task automatic tick(input bit do_rst = 0);
    int k, done_at, win;
    bit done_now, en_now, p2, hold_wait;
    logic [15:0] ra;
    @(posedge clk); #1;
    if (auto_req)
      for (int i = 0; i < 3; i++)
        if (!pend[i] && $urandom_range(0, 99) < req_rate) begin
          ra = 16'($urandom);
          if ($urandom_range(0, 3) == 0) ra = 16'hFF00 | {8'h00, ra[7:0]};
          new_req(i, ra, 1'($urandom), 1'($urandom), 16'($urandom));
        end
    rst = do_rst;
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = pend[i]; req_we[i] = p_we[i]; req_byte[i] = p_byte[i];
      req_addr[16*i +: 16] = p_addr[i]; req_wdata[16*i +: 16] = p_wdata[i];
    end
    k = cyc - g_cyc - 1;
    hold_wait  = busy && k >= 0 && k < g_w;
    mem_wait   = (busy && !g_mmio) ? hold_wait : 1'($urandom);
    mmio_wait  = (busy &&  g_mmio) ? hold_wait : 1'($urandom);
    mem_rdata  = 16'($urandom);
    mmio_rdata = 16'($urandom);
    @(negedge clk);
    if (do_rst) begin
      chk("gnt_in_rst", {29'd0, req_gnt}, 32'd0);
      busy = 0; losses = 0; cyc++;
      return;
    end
    done_at  = g_cyc + 2 + (g_w > 255 ? 255 : g_w);
    done_now = busy && cyc == done_at;
    en_now   = busy && cyc > g_cyc && cyc < done_at;
    if (busy && g_w <= 255 && cyc == g_cyc + 1 + g_w)
      exp_rdata = g_mmio ? mmio_rdata : mem_rdata;
    chk("done", {29'd0, req_done}, done_now ? (32'd1 << g_idx) : 32'd0);
    if (done_now) begin
      chk("err", {31'd0, req_err}, {31'd0, g_w > 255});
      chk("rdata", {16'd0, rdata}, (g_we || g_w > 255) ? 32'd0 : {16'd0, exp_rdata});
    end
    chk("mem_en",  {31'd0, mem_en},  {31'd0, en_now && !g_mmio});
    chk("mmio_en", {31'd0, mmio_en}, {31'd0, en_now &&  g_mmio});
    if (en_now) begin
      chk("bus_addr", {16'd0, bus_addr}, {16'd0, 1'b0, g_addr[15:1]});
      chk("byte_sel", {31'd0, bus_byte_select}, {31'd0, g_addr[0]});
      chk("byte_en",  {31'd0, bus_byte_enable}, {31'd0, g_byte});
      chk("bus_we",   {31'd0, bus_we}, {31'd0, g_we});
      chk("wdata",    {16'd0, bus_wdata}, {16'd0, g_wdata});
    end
    win = -1;
    if (!busy || done_now) begin
      if (pend[2] && losses >= 4) win = 2;
      else for (int i = 2; i >= 0; i--) if (pend[i]) win = i;
    end
    chk("gnt", {29'd0, req_gnt}, win >= 0 ? (32'd1 << win) : 32'd0);
    p2 = pend[2];
    if (done_now) busy = 0;
    if (win >= 0) begin
      if (win == 2) losses = 0;
      else if (p2)  losses = (losses < 4) ? losses + 1 : 4;
      g_idx = win; g_addr = p_addr[win]; g_we = p_we[win]; g_byte = p_byte[win];
      g_wdata = p_wdata[win]; g_mmio = (p_addr[win] >= 16'hFF00);
      g_cyc = cyc; busy = 1; pend[win] = 0; gcount[win]++;
      g_w = (w_next >= 0) ? w_next
          : ($urandom_range(0, 2) == 0 ? int'($urandom_range(1, 4)) : 0);
    end
    if (!p2) losses = 0;
    cyc++;
  endtask

  initial begin
    rst = 1; req_valid = 0; req_addr = 0; req_we = 0; req_byte = 0; req_wdata = 0;
    mem_rdata = 0; mmio_rdata = 0; mem_wait = 0; mmio_wait = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt",  {29'd0, req_gnt}, 32'd0);
    chk("rst_done", {29'd0, req_done}, 32'd0);
    chk("rst_err",  {31'd0, req_err}, 32'd0);
    chk("rst_rdata", {16'd0, rdata}, 32'd0);
    chk("rst_en",   {30'd0, mem_en, mmio_en}, 32'd0);
    chk("rst_bus",  {16'd0, bus_addr}, 32'd0);
    chk("rst_we",   {31'd0, bus_we}, 32'd0);
    rst = 0;

    // single fetch, zero wait
    w_next = 0; new_req(1, 16'h0010, 0, 0, 16'h0000);
    repeat (4) tick();
    // data and fetch together: back-to-back through DONE
    new_req(0, 16'h0200, 0, 0, 16'h0000); new_req(1, 16'h0302, 0, 0, 16'h0000);
    repeat (6) tick();
    // byte write into mmio
    new_req(0, 16'hFF03, 1, 1, 16'h00A5);
    repeat (4) tick();
    // three wait cycles, then a timeout
    w_next = 3;   new_req(1, 16'h1234, 0, 0, 16'h0000); repeat (8) tick();
    w_next = 300; new_req(0, 16'h0100, 0, 0, 16'h0000); repeat (262) tick();
    // data and DMA continuously valid: DMA wins every fifth grant
    w_next = 0;
    gcount[0] = 0; gcount[2] = 0;
    repeat (40) begin
      if (!pend[0]) new_req(0, 16'h0400, 0, 0, 16'h0000);
      if (!pend[2]) new_req(2, 16'h0800, 1, 0, 16'h5A5A);
      tick();
    end
    chk("starve_ratio", gcount[0], 4 * gcount[2]);
    pend[0] = 0; pend[2] = 0; losses = 0;
    repeat (4) tick();
    // reset during a stall; pending request granted once reset falls
    w_next = 50; new_req(1, 16'h0042, 0, 0, 16'h0000);
    repeat (4) tick();
    new_req(0, 16'h0600, 0, 0, 16'h0000);
    tick(1);
    w_next = 0;
    repeat (4) tick();
    // random traffic
    w_next = -1; auto_req = 1;
    repeat (500) tick();
    auto_req = 0;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
